sram_like_slave: RTL and testbench

- Synthesizable responder for the sram-like protocol that the CPU core drives on its inst and data ports: req/wr/size/addr/wdata in, addr_ok/data_ok/rdata out.
- Backed by an internal word-addressed memory; queues accepted requests in order and returns each response after a fixed minimum latency.
- Instantiated once per port in the SoC/test top: one for inst, one for data. Lets the core be run against a deterministic memory without the AXI bridge.

---
 rtl/sram_like_slave.sv | 74 +++++++
 tb/tb_sram_like_slave.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sram_like_slave.sv
// sram_like_slave: in-order sram-like responder over a word memory with a fixed minimum response latency.
// Define SRAM_LIKE_RAND_STALL_EN to add LFSR-driven accept and response stalls.
module sram_like_slave #(
    parameter int MEM_AW = 12,
    parameter int DEPTH  = 4,
    parameter int LAT    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sram_req,
    input  logic        sram_wr,
    input  logic [1:0]  sram_size,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    output logic        sram_addrok,
    output logic        sram_dataok
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
    logic [31:0] mem [2**MEM_AW];
    logic [31:0] q_data [DEPTH];
    logic [3:0] q_age [DEPTH];
    logic [PW-1:0] head, tail;
    logic [PW:0] count;
    logic [MEM_AW-1:0] idx;
    logic [3:0] be;
    logic push, pop, acc_ok, pop_ok;
    logic unused_addr;
`ifdef SRAM_LIKE_RAND_STALL_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk)
        if (reset) lfsr <= 16'h1;
        else lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0);
    assign acc_ok = !lfsr[0];
    assign pop_ok = !lfsr[1];
`else
    assign acc_ok = 1'b1;
    assign pop_ok = 1'b1;
`endif
    assign unused_addr = ^sram_addr[31:MEM_AW+2];
    assign idx = sram_addr[MEM_AW+1:2];
    assign sram_addrok = sram_req && count != FULL && acc_ok;
    assign push = sram_addrok;
    assign pop = count != '0 && q_age[head] == 4'd0 && pop_ok;
    assign sram_dataok = pop;
    // write entries carry zero data, so the head word is the response as-is
    assign sram_rdata = pop ? q_data[head] : 32'd0;
    assign be = sram_size == 2'd0 ? 4'b0001 << sram_addr[1:0] :
                sram_size == 2'd1 ? 4'b0011 << {sram_addr[1], 1'b0} :
                sram_size == 2'd2 ? 4'b1111 : 4'b0000;
    always_ff @(posedge clk)
        if (!reset && push && sram_wr)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[idx][8*b +: 8] <= sram_wdata[8*b +: 8];
    always_ff @(posedge clk) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) q_age[i] <= 4'd0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (q_age[i] != 4'd0) q_age[i] <= q_age[i] - 4'd1;
            if (push) begin
                q_data[tail] <= sram_wr || sram_size == 2'd3 ? 32'd0 : mem[idx];
                q_age[tail] <= 4'(LAT - 1);
                tail <= tail + 1'b1;
            end
            if (pop) head <= head + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_sram_like_slave.sv
// tb_sram_like_slave: three instances (LAT 1/3/5) on shared inputs, checked against a queue-based model.
module tb_sram_like_slave;
    typedef struct packed { int ready; logic [31:0] data; } ent_t;
    logic clk = 0, reset = 1, req = 0, wr = 0;
    logic [1:0] size = 0;
    logic [31:0] addr = 0, wdata = 0;
    logic [31:0] rdata [3];
    logic addrok [3], dataok [3];
    ent_t mq [3][$];
    logic [31:0] mm [3][4096];
    int cyc = 0, checks = 0, failures = 0;

    always #5 clk = ~clk;

    sram_like_slave #(.LAT(1)) u0 (.clk(clk), .reset(reset), .sram_req(req), .sram_wr(wr), .sram_size(size),
        .sram_addr(addr), .sram_wdata(wdata), .sram_rdata(rdata[0]), .sram_addrok(addrok[0]), .sram_dataok(dataok[0]));
    sram_like_slave #(.LAT(3)) u1 (.clk(clk), .reset(reset), .sram_req(req), .sram_wr(wr), .sram_size(size),
        .sram_addr(addr), .sram_wdata(wdata), .sram_rdata(rdata[1]), .sram_addrok(addrok[1]), .sram_dataok(dataok[1]));
    sram_like_slave #(.LAT(5)) u2 (.clk(clk), .reset(reset), .sram_req(req), .sram_wr(wr), .sram_size(size),
        .sram_addr(addr), .sram_wdata(wdata), .sram_rdata(rdata[2]), .sram_addrok(addrok[2]), .sram_dataok(dataok[2]));

    function automatic int lat_of(int i);
        return i == 0 ? 1 : i == 1 ? 3 : 5;
    endfunction

    task automatic chk(string name, int i, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s u%0d actual=%h expected=%h cyc=%0d", name, i, act, exp, cyc);
        end
    endtask

    // Model: each accepted request becomes ready LAT cycles later; only the oldest may respond.
    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) mq[i].delete();
        end else begin
            for (int i = 0; i < 3; i++) begin
                logic ed, ea;
                logic [31:0] w;
                int ix, ln;
                ed = mq[i].size() > 0 && cyc >= mq[i][0].ready;
                ea = req && mq[i].size() < 4;
`ifdef SRAM_LIKE_RAND_STALL_EN
                chk("addrok_allowed", i, 32'(addrok[i] & ~ea), 0);
                chk("dataok_allowed", i, 32'(dataok[i] & ~ed), 0);
                ea = addrok[i];
                ed = dataok[i];
`else
                chk("addrok", i, 32'(addrok[i]), 32'(ea));
                chk("dataok", i, 32'(dataok[i]), 32'(ed));
`endif
                if (ed) begin
                    chk("rdata", i, rdata[i], mq[i][0].data);
                    void'(mq[i].pop_front());
                end
                if (ea) begin
                    ix = int'(addr[13:2]);
                    ln = int'(addr[1:0]);
                    w = mm[i][ix];
                    if (wr) begin
                        if (size == 2'd0) w[8*ln +: 8] = wdata[8*ln +: 8];
                        else if (size == 2'd1) w[16*(ln/2) +: 16] = wdata[16*(ln/2) +: 16];
                        else if (size == 2'd2) w = wdata;
                        mm[i][ix] = w;
                        mq[i].push_back(ent_t'{cyc + lat_of(i), 32'd0});
                    end else
                        mq[i].push_back(ent_t'{cyc + lat_of(i), size == 2'd3 ? 32'd0 : w});
                end
            end
        end
        cyc++;
    end

    task automatic drive(logic r, logic w, logic [1:0] s, logic [31:0] a, logic [31:0] d);
        req = r; wr = w; size = s; addr = a; wdata = d;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic single(logic w, logic [1:0] s, logic [31:0] a, logic [31:0] d);
        drive(1'b1, w, s, a, d);
        tick();
        drive(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    endtask

    initial begin
        logic [8:0] p1, p2d;
        logic [5:0] p2a;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_dataok", i, 32'(dataok[i]), 0);
            chk("rst_addrok", i, 32'(addrok[i]), 0);
            chk("rst_rdata", i, rdata[i], 0);
        end
        tick();
        for (int w = 0; w < 16; w++) begin
            single(1'b1, 2'd2, 32'(w * 4), $urandom);
            repeat (6) tick();
        end
        // write then read back-to-back on the LAT=1 instance
        drive(1'b1, 1'b1, 2'd2, 32'h10, 32'hDEADBEEF);
        tick();
        drive(1'b1, 1'b0, 2'd2, 32'h10, 32'd0);
        @(negedge clk);
        chk("raw_wr_dataok", 0, 32'(dataok[0]), 1);
        chk("raw_wr_rdata", 0, rdata[0], 0);
        tick();
        drive(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        @(negedge clk);
        chk("raw_rd_dataok", 0, 32'(dataok[0]), 1);
        chk("raw_rdata", 0, rdata[0], 32'hDEADBEEF);
        repeat (7) tick();
        single(1'b1, 2'd2, 32'h10, 32'h11223344);
        single(1'b1, 2'd0, 32'h13, 32'hAA000000);
        single(1'b0, 2'd2, 32'h10, 32'd0);
        @(negedge clk);
        chk("byte_merge", 0, rdata[0], 32'hAA223344);
        repeat (7) tick();
        single(1'b1, 2'd1, 32'h12, 32'h55660000);
        single(1'b0, 2'd2, 32'h10, 32'd0);
        @(negedge clk);
        chk("half_merge", 0, rdata[0], 32'h55663344);
        repeat (7) tick();
        single(1'b1, 2'd2, 32'h4000, 32'h1);
        single(1'b0, 2'd2, 32'h0, 32'd0);
        @(negedge clk);
        chk("addr_wrap", 0, rdata[0], 32'h1);
        repeat (8) tick();
        for (int k = 0; k < 9; k++) begin
            if (k < 6) drive(1'b1, 1'b0, 2'd2, 32'h10, 32'd0);
            else drive(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
            @(negedge clk);
            p1[k] = dataok[1];
            p2d[k] = dataok[2];
            if (k < 6) p2a[k] = addrok[2];
            tick();
        end
        chk("lat3_dataok_pattern", 1, 32'(p1), 32'(9'b111111000));
        chk("lat5_dataok_pattern", 2, 32'(p2d), 32'(9'b111100000));
        chk("full_no_bypass", 2, 32'(p2a), 32'(6'b001111));
        repeat (10) tick();
        drive(1'b1, 1'b0, 2'd2, 32'h10, 32'd0);
        tick();
        tick();
        drive(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        reset = 1;
        tick();
        reset = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) chk("post_rst_dataok", i, 32'(dataok[i]), 0);
            tick();
        end
        drive(1'b1, 1'b0, 2'd2, 32'h10, 32'd0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk("post_rst_addrok", i, 32'(addrok[i]), 1);
        tick();
        drive(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        repeat (8) tick();
        for (int n = 0; n < 1000; n++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            drive($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom);
            tick();
        end
        drive(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        repeat (20) tick();
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk("drain", i, 32'(mq[i].size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
